// File: rtl/mem_access_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_access_stage_pkg
//   Shared definitions for the MEM pipeline stage: default datapath width,
//   default access timeout and the IDLE/WAIT state encoding.
// ---------------------------------------------------------------------------
package mem_access_stage_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_TIMEOUT = 15;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_access_stage_mem_wb_reg.sv
// ---------------------------------------------------------------------------
// mem_wb_reg
//   MEM/WB pipeline register. Every clock edge it captures either the
//   presented write-back fields or a bubble (all fields zero).
// Ports
//   CLK, Reset          clock, asynchronous active-low reset
//   bubble              1 = load a bubble instead of the *_next fields
//   *_next              write-back fields to capture
//   *_reg               registered write-back fields
// ---------------------------------------------------------------------------
module mem_wb_reg #(
  parameter int WIDTH = 16
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             bubble,
  input  logic             reg_write_next,
  input  logic             reg_store_next,
  input  logic [WIDTH-1:0] alu_result_next,
  input  logic [WIDTH-1:0] mem_data_next,
  input  logic [WIDTH-1:0] rd_next,
  output logic             reg_write_reg,
  output logic             reg_store_reg,
  output logic [WIDTH-1:0] alu_result_reg,
  output logic [WIDTH-1:0] mem_data_reg,
  output logic [WIDTH-1:0] rd_reg
);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset || bubble) begin
      reg_write_reg  <= 1'b0;
      reg_store_reg  <= 1'b0;
      alu_result_reg <= '0;
      mem_data_reg   <= '0;
      rd_reg         <= '0;
    end else begin
      reg_write_reg  <= reg_write_next;
      reg_store_reg  <= reg_store_next;
      alu_result_reg <= alu_result_next;
      mem_data_reg   <= mem_data_next;
      rd_reg         <= rd_next;
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// ---------------------------------------------------------------------------
// mem_access_stage
//   MEM pipeline stage. Non-memory ops pass to MEM/WB in one cycle. Loads and
//   stores latch their operands, raise MemReq and wait (stalling upstream) for
//   a one-cycle MemAck, or give up after TIMEOUT wait cycles and set the sticky
//   MemErr flag.
// Ports
//   CLK, Reset                         clock, asynchronous active-low reset
//   IRegWrite..IRd                     EX/MEM register fields
//   MemReq/MemWe/MemAddr/MemWData      memory request side (valid while MemReq)
//   MemRData/MemAck                    memory response side
//   Stall                              1 = EX/MEM must hold
//   MemErr                             sticky timeout flag
//   ORegWrite..ORd                     MEM/WB register fields
// ---------------------------------------------------------------------------
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             IRegWrite,
  input  logic             IMemWrite,
  input  logic             IMemRead,
  input  logic             IRegStore,
  input  logic [WIDTH-1:0] IALUResult,
  input  logic [WIDTH-1:0] I3rdArg,
  input  logic [WIDTH-1:0] IRd,
  output logic             MemReq,
  output logic             MemWe,
  output logic [WIDTH-1:0] MemAddr,
  output logic [WIDTH-1:0] MemWData,
  input  logic [WIDTH-1:0] MemRData,
  input  logic             MemAck,
  output logic             Stall,
  output logic             MemErr,
  output logic             ORegWrite,
  output logic             ORegStore,
  output logic [WIDTH-1:0] OALUResult,
  output logic [WIDTH-1:0] OMemData,
  output logic [WIDTH-1:0] ORd
);

  localparam int             CW       = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]  CNT_MAX  = CW'(TIMEOUT);

  state_t            state_reg, state_next;
  logic [CW-1:0]     cnt_reg, cnt_next;
  logic              err_reg, err_next;

  // Operands captured on IDLE->WAIT; the write-back fields are held too so the
  // result does not depend on upstream keeping its inputs after the handshake.
  logic              we_reg;
  logic [WIDTH-1:0]  addr_reg;
  logic [WIDTH-1:0]  wdata_reg;
  logic [WIDTH-1:0]  rd_hold_reg;
  logic              reg_write_hold_reg;
  logic              reg_store_hold_reg;

  logic              memop;
  logic              capture;
  logic              stall_raw;
  logic              wb_bubble;
  logic              wb_from_hold;
  logic [WIDTH-1:0]  wb_mem_data;

  assign memop = IMemRead | IMemWrite;

  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    err_next     = err_reg;
    capture      = 1'b0;
    stall_raw    = 1'b0;
    wb_bubble    = 1'b1;
    wb_from_hold = 1'b0;
    wb_mem_data  = '0;
    case (state_reg)
      S_IDLE: begin
        if (memop) begin
          stall_raw  = 1'b1;
          capture    = 1'b1;
          cnt_next   = '0;
          state_next = S_WAIT;
        end else begin
          wb_bubble  = 1'b0;
        end
      end
      S_WAIT: begin
        if (MemAck) begin
          wb_bubble    = 1'b0;
          wb_from_hold = 1'b1;
          wb_mem_data  = we_reg ? '0 : MemRData;
          cnt_next     = '0;
          state_next   = S_IDLE;
        end else if (cnt_reg >= CNT_LAST) begin
          // Abandoned access completes like a normal one but with zero data.
          wb_bubble    = 1'b0;
          wb_from_hold = 1'b1;
          err_next     = 1'b1;
          cnt_next     = '0;
          state_next   = S_IDLE;
        end else begin
          stall_raw    = 1'b1;
          cnt_next     = (cnt_reg == CNT_MAX) ? cnt_reg : cnt_reg + CW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_reg          <= S_IDLE;
      cnt_reg            <= '0;
      err_reg            <= 1'b0;
      we_reg             <= 1'b0;
      addr_reg           <= '0;
      wdata_reg          <= '0;
      rd_hold_reg        <= '0;
      reg_write_hold_reg <= 1'b0;
      reg_store_hold_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      err_reg   <= err_next;
      if (capture) begin
        we_reg             <= IMemWrite;  // write wins when both are set
        addr_reg           <= IALUResult;
        wdata_reg          <= I3rdArg;
        rd_hold_reg        <= IRd;
        reg_write_hold_reg <= IRegWrite;
        reg_store_hold_reg <= IRegStore;
      end
    end
  end

  mem_wb_reg #(.WIDTH(WIDTH)) u_mem_wb (
    .CLK             (CLK),
    .Reset           (Reset),
    .bubble          (wb_bubble),
    .reg_write_next  (wb_from_hold ? reg_write_hold_reg : IRegWrite),
    .reg_store_next  (wb_from_hold ? reg_store_hold_reg : IRegStore),
    .alu_result_next (wb_from_hold ? addr_reg : IALUResult),
    .mem_data_next   (wb_mem_data),
    .rd_next         (wb_from_hold ? rd_hold_reg : IRd),
    .reg_write_reg   (ORegWrite),
    .reg_store_reg   (ORegStore),
    .alu_result_reg  (OALUResult),
    .mem_data_reg    (OMemData),
    .rd_reg          (ORd)
  );

  assign MemReq   = (state_reg == S_WAIT);
  assign MemWe    = we_reg;
  assign MemAddr  = addr_reg;
  assign MemWData = wdata_reg;
  assign MemErr   = err_reg;
  // Gated so Stall is low during reset even if a memop sits on the inputs.
  assign Stall    = stall_raw & Reset;

endmodule

// File: tb/tb_mem_access_stage.sv
module tb_mem_access_stage;

  localparam int W  = 16;
  localparam int TO = 15;

  logic         CLK = 1'b0;
  logic         Reset = 1'b0;
  logic         IRegWrite = 1'b0, IMemWrite = 1'b0, IMemRead = 1'b0, IRegStore = 1'b0;
  logic [W-1:0] IALUResult = '0, I3rdArg = '0, IRd = '0;
  logic         MemReq, MemWe, Stall, MemErr, ORegWrite, ORegStore;
  logic [W-1:0] MemAddr, MemWData, OALUResult, OMemData, ORd;
  logic [W-1:0] MemRData = '0;
  logic         MemAck = 1'b0;

  mem_access_stage #(.WIDTH(W), .TIMEOUT(TO)) dut (
    .CLK(CLK), .Reset(Reset),
    .IRegWrite(IRegWrite), .IMemWrite(IMemWrite), .IMemRead(IMemRead),
    .IRegStore(IRegStore), .IALUResult(IALUResult), .I3rdArg(I3rdArg), .IRd(IRd),
    .MemReq(MemReq), .MemWe(MemWe), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemRData(MemRData), .MemAck(MemAck), .Stall(Stall), .MemErr(MemErr),
    .ORegWrite(ORegWrite), .ORegStore(ORegStore), .OALUResult(OALUResult),
    .OMemData(OMemData), .ORd(ORd)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic         rw, rs, err;
    logic [W-1:0] alu, md, rd;
  } exp_t;

  typedef struct {
    int           delay;   // wait cycles before ack; >= TO means never ack
    logic [W-1:0] rdata, addr, wdata;
    logic         we;
  } plan_t;

  exp_t  exp_q[$];
  plan_t plan_q[$];
  int    tests = 0;
  int    fails = 0;
  logic  in_valid = 1'b0;
  logic  err_model = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, {MemReq, Stall, MemErr, MemWe, MemAddr, MemWData,
               ORegWrite, ORegStore, OALUResult, OMemData, ORd}, 64'd0);
  endtask

  // Monitor: every accepted instruction (Stall low while one is presented)
  // must appear in MEM/WB after that edge; otherwise MEM/WB holds zeros.
  logic stall_s, valid_s, rst_s;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge CLK);
      stall_s = Stall; valid_s = in_valid; rst_s = Reset;
      @(posedge CLK);
      #1;
      if (rst_s && Reset) begin
        if (!stall_s && valid_s) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_retire", 64'd1, 64'd0);
          end else begin
            mon_e = exp_q.pop_front();
            chk("ORegWrite",  ORegWrite,  mon_e.rw);
            chk("ORegStore",  ORegStore,  mon_e.rs);
            chk("OALUResult", OALUResult, mon_e.alu);
            chk("OMemData",   OMemData,   mon_e.md);
            chk("ORd",        ORd,        mon_e.rd);
            chk("MemErr",     MemErr,     mon_e.err);
          end
        end else begin
          chk("wb_bubble", {ORegWrite, ORegStore, OALUResult, OMemData, ORd}, 64'd0);
        end
      end
    end
  end

  // Memory model: serves requests according to the plan queue, and throws
  // random spurious acks while no request is outstanding.
  plan_t cur;
  logic  active = 1'b0;
  int    k = 0;
  initial begin
    forever begin
      @(posedge CLK);
      #1;
      MemAck = 1'b0;
      if (!Reset) begin
        active = 1'b0;
      end else if (MemReq) begin
        if (!active) begin
          if (plan_q.size() == 0) begin
            chk("unexpected_req", 64'd1, 64'd0);
            cur.delay = 0; cur.rdata = '0; cur.addr = MemAddr; cur.wdata = MemWData; cur.we = MemWe;
          end else begin
            cur = plan_q.pop_front();
          end
          active = 1'b1;
          k = 0;
        end else begin
          k++;
        end
        chk("MemAddr", MemAddr, cur.addr);
        chk("MemWe",   MemWe,   cur.we);
        if (cur.we) chk("MemWData", MemWData, cur.wdata);
        if (k == cur.delay) begin
          MemAck = 1'b1;
          MemRData = cur.rdata;
          active = 1'b0;
        end
      end else begin
        if (active) begin
          chk("timeout_req_len", k + 1, TO);
          active = 1'b0;
        end
        if ($urandom_range(3) == 0) begin
          MemAck = 1'b1;
          MemRData = 16'($urandom);
        end
      end
    end
  end

  task automatic drive_nop();
    IRegWrite = 1'b0; IMemWrite = 1'b0; IMemRead = 1'b0; IRegStore = 1'b0;
    IALUResult = '0; I3rdArg = '0; IRd = '0;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    drive_nop();
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 load+store (store wins)
  task automatic issue(input int kind, input logic [W-1:0] alu, input logic [W-1:0] wdata,
                       input logic [W-1:0] rd, input logic rw, input logic rs,
                       input int delay, input logic [W-1:0] rdata);
    exp_t  e;
    plan_t p;
    int    stalls, exp_stalls;
    logic  s;
    IRegWrite = rw; IRegStore = rs; IALUResult = alu; I3rdArg = wdata; IRd = rd;
    IMemRead  = (kind == 1 || kind == 3);
    IMemWrite = (kind >= 2);
    in_valid  = 1'b1;
    e.rw = rw; e.rs = rs; e.alu = alu; e.rd = rd; e.md = '0;
    if (kind != 0) begin
      if (delay >= TO) err_model = 1'b1;
      else if (kind == 1) e.md = rdata;
      p.delay = delay; p.rdata = rdata; p.addr = alu; p.wdata = wdata; p.we = (kind >= 2);
      plan_q.push_back(p);
      exp_stalls = 1 + ((delay >= TO) ? TO - 1 : delay);
    end else begin
      exp_stalls = 0;
    end
    e.err = err_model;
    exp_q.push_back(e);
    stalls = 0;
    forever begin
      @(negedge CLK);
      s = Stall;
      @(posedge CLK);
      #1;
      if (!s) break;
      stalls++;
      if (stalls > TO + 5) begin
        chk("stall_timeout", 64'd1, 64'd0);
        break;
      end
    end
    chk("stall_cycles", stalls, exp_stalls);
    $display("[TB] op kind=%0d addr=%h wdata=%h rd=%h delay=%0d stalls=%0d",
             kind, alu, wdata, rd, delay, stalls);
    drive_nop();
  endtask

  // Reset asserted while a load is waiting: everything must drop at once.
  task automatic reset_mid_access();
    plan_t p;
    int    n;
    IMemRead = 1'b1; IMemWrite = 1'b0; IALUResult = 16'h0ABC; IRd = 16'd9;
    IRegWrite = 1'b1; IRegStore = 1'b1; in_valid = 1'b1;
    p.delay = TO + 5; p.rdata = '0; p.addr = 16'h0ABC; p.wdata = '0; p.we = 1'b0;
    plan_q.push_back(p);
    n = 0;
    while (n < 5) begin
      @(negedge CLK);
      if (MemReq) break;
      n++;
    end
    chk("reset_test_req_seen", MemReq, 1'b1);
    repeat (2) @(negedge CLK);
    #2 Reset = 1'b0;
    #1 chk_all_zero("async_reset");
    plan_q.delete();
    err_model = 1'b0;
    drive_nop();
    @(negedge CLK);
    #2 Reset = 1'b1;
    @(posedge CLK);
    #1;
    $display("[TB] op reset during access");
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, r, dly;
    drive_nop();
    #3 chk_all_zero("reset_state");
    repeat (2) @(negedge CLK);
    #2 Reset = 1'b1;
    @(posedge CLK);
    #1;
    idle(2);
    issue(0, 16'h1234, 16'h0000, 16'd3, 1'b1, 1'b0, 0, 16'h0000);      // ALU pass-through
    issue(1, 16'h0040, 16'h0000, 16'd5, 1'b1, 1'b1, 3, 16'hBEEF);      // load, 3 wait cycles
    issue(2, 16'h0010, 16'h00AA, 16'd6, 1'b1, 1'b0, 0, 16'h0000);      // store, immediate ack
    issue(3, 16'h0020, 16'h0055, 16'd2, 1'b0, 1'b0, 1, 16'h7777);      // both set: write wins
    issue(1, 16'h0080, 16'h0000, 16'd7, 1'b1, 1'b1, TO + 2, 16'h1111); // timeout
    issue(1, 16'h0082, 16'h0000, 16'd8, 1'b1, 1'b1, TO - 1, 16'h2222); // ack on last cycle
    issue(1, 16'h0084, 16'h0000, 16'd4, 1'b1, 1'b1, 1, 16'h3333);      // back-to-back load
    idle(4);                                                           // spurious acks ignored
    reset_mid_access();
    idle(1);
    chk("memerr_after_reset", MemErr, 1'b0);
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(3) == 0) idle($urandom_range(1, 3));
      kind = $urandom_range(3);
      r = $urandom_range(19);
      if (r == 0)      dly = TO + $urandom_range(2);
      else if (r == 1) dly = TO - 1;
      else             dly = $urandom_range(4);
      issue(kind, 16'($urandom), 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
            dly, 16'($urandom));
    end
    idle(3);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
